mem_access_controller: RTL

//  Sequences every RAM transaction of the SPARC V8 datapath.
//  - Arbitrates the RAM between two requesters: instruction fetch and data load/store.
//  - Drives MAR/MDR loads and the RAM handshake (RAM_enable/RAM_OpCode, waits on MFC).
//  - Signals completion, or raises a trap (misaligned, timeout) toward ControlUnit.

---
 rtl/mem_access_controller_pkg.sv | 70 +++++++
 rtl/mem_access_controller_if.sv | 37 +++
 rtl/mem_access_controller_arbiter.sv | 45 ++++
 rtl/mem_access_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_controller_pkg.sv
// Shared constants for the memory access controller: SPARC op3 codes for the
// supported loads/stores, trap types, FSM state encoding and decode helpers.
package mem_access_controller_pkg;

  // Load op3 codes
  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;
  // Store op3 codes
  localparam logic [5:0] OP3_ST   = 6'b000100;
  localparam logic [5:0] OP3_STB  = 6'b000101;
  localparam logic [5:0] OP3_STH  = 6'b000110;

  // Trap types reported on trap_tt
  localparam logic [7:0] TT_NONE             = 8'h00;
  localparam logic [7:0] TT_ILLEGAL_INSTR    = 8'h02;
  localparam logic [7:0] TT_MEM_NOT_ALIGNED  = 8'h07;
  localparam logic [7:0] TT_INSTR_ACCESS_ERR = 8'h21;
  localparam logic [7:0] TT_DATA_ACCESS_ERR  = 8'h29;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // Access width implied by an op3; SZ_BAD marks an unsupported op3
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } acc_size_e;

  function automatic acc_size_e op3_size(input logic [5:0] op3);
    acc_size_e sz;
    case (op3)
      OP3_LD, OP3_ST:             sz = SZ_WORD;
      OP3_LDUH, OP3_LDSH, OP3_STH: sz = SZ_HALF;
      OP3_LDUB, OP3_LDSB, OP3_STB: sz = SZ_BYTE;
      default:                    sz = SZ_BAD;
    endcase
    return sz;
  endfunction

  function automatic logic op3_is_store(input logic [5:0] op3);
    logic st;
    case (op3)
      OP3_ST, OP3_STB, OP3_STH: st = 1'b1;
      default:                  st = 1'b0;
    endcase
    return st;
  endfunction

  // Low address bits that must be zero for the given access width
  function automatic logic addr_misaligned(input acc_size_e sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_WORD: bad = (lo != 2'b00);
      SZ_HALF: bad = lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Requester, MAR/MDR and RAM handshake signals of the memory access controller.
// master: the controller; slave: requesters, datapath and RAM around it.
interface mem_access_controller_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic        data_req;
  logic [5:0]  data_op3;
  logic [31:0] data_addr;
  logic        data_done;
  logic        gnt_fetch;
  logic        gnt_data;
  logic        trap;
  logic [7:0]  trap_tt;
  logic [31:0] mem_addr;
  logic        MAR_Enable;
  logic        MDR_Enable;
  logic        MDR_Mux_select;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic        MFC;
  logic        busy;

  modport master (
    input  fetch_req, fetch_addr, data_req, data_op3, data_addr, MFC,
    output fetch_done, data_done, gnt_fetch, gnt_data, trap, trap_tt,
           mem_addr, MAR_Enable, MDR_Enable, MDR_Mux_select,
           RAM_enable, RAM_OpCode, busy
  );

  modport slave (
    output fetch_req, fetch_addr, data_req, data_op3, data_addr, MFC,
    input  fetch_done, data_done, gnt_fetch, gnt_data, trap, trap_tt,
           mem_addr, MAR_Enable, MDR_Enable, MDR_Mux_select,
           RAM_enable, RAM_OpCode, busy
  );
endinterface

// File: rtl/mem_access_controller_arbiter.sv
// Two-way round-robin request arbiter (fetch vs. data). Grants are only
// issued while enable is high; a tie goes to the side not granted last.
// After reset the last grant is taken to be data, so fetch wins the first tie.
module mem_access_controller_arbiter (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic fetch_req,
  input  logic data_req,
  output logic gnt_fetch,
  output logic gnt_data
);

  logic last_data_r;
  logic pick_data_s;

  // Pick the winner: a lone request wins, a tie flips against the last grant.
  always_comb begin
    pick_data_s = 1'b0;
    if (fetch_req && data_req) begin
      pick_data_s = ~last_data_r;
    end else if (data_req) begin
      pick_data_s = 1'b1;
    end else begin
      pick_data_s = 1'b0;
    end
  end

  assign gnt_data  = enable & data_req & pick_data_s;
  assign gnt_fetch = enable & fetch_req & ~pick_data_s;

  // Remember which requester was served last.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_data_r <= 1'b1;
    end else if (gnt_data) begin
      last_data_r <= 1'b1;
    end else if (gnt_fetch) begin
      last_data_r <= 1'b0;
    end else begin
      last_data_r <= last_data_r;
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// Memory access controller: arbitrates instruction fetch vs. data load/store,
// sequences MAR/MDR loads and the RAM handshake, and reports completion or a
// trap (illegal op3, misaligned address, optional access timeout).
// Optional feature: define MEM_TIMEOUT_EN to trap an ACCESS phase that sees no
// MFC within TIMEOUT_CYCLES cycles; without it ACCESS waits for MFC forever.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
)
(
  input logic                     Clk,
  input logic                     Clr,
  mem_access_controller_if.master bus
);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic        data_sel_r;   // 1: current access belongs to the data requester
  logic [5:0]  op_r;
  logic [31:0] addr_r;
  logic [7:0]  trap_tt_r;
  logic [7:0]  tt_s;
  logic        idle_s;
  logic        gnt_fetch_s;
  logic        gnt_data_s;
  logic        timeout_s;
  acc_size_e   size_s;

  assign idle_s = (state_r == ST_IDLE);
  assign size_s = op3_size(op_r);

  mem_access_controller_arbiter u_arbiter (
    .clk       (Clk),
    .clr       (Clr),
    .enable    (idle_s),
    .fetch_req (bus.fetch_req),
    .data_req  (bus.data_req),
    .gnt_fetch (gnt_fetch_s),
    .gnt_data  (gnt_data_s)
  );

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  // Count ACCESS cycles; the count restarts every time ACCESS is entered.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt_r <= '0;
    end else if (state_r == ST_ACCESS) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ST_ACCESS) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and trap-type selection.
  always_comb begin
    state_s = state_r;
    tt_s    = trap_tt_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_fetch_s || gnt_data_s) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (size_s == SZ_BAD) begin
          state_s = ST_TRAP;
          tt_s    = TT_ILLEGAL_INSTR;
        end else if (addr_misaligned(size_s, addr_r[1:0])) begin
          state_s = ST_TRAP;
          tt_s    = TT_MEM_NOT_ALIGNED;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // MFC has priority over a timeout expiring in the same cycle
        if (bus.MFC) begin
          if (op3_is_store(op_r)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LATCH;
          end
        end else if (timeout_s) begin
          state_s = ST_TRAP;
          tt_s    = data_sel_r ? TT_DATA_ACCESS_ERR : TT_INSTR_ACCESS_ERR;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_LATCH: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      ST_TRAP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register; trap_tt is captured on entry to TRAP and held afterwards.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_r   <= ST_IDLE;
      trap_tt_r <= TT_NONE;
    end else begin
      state_r <= state_s;
      if (state_s == ST_TRAP) begin
        trap_tt_r <= tt_s;
      end else begin
        trap_tt_r <= trap_tt_r;
      end
    end
  end

  // Latch the granted request so the requester may drop it after the grant.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      data_sel_r <= 1'b0;
      op_r       <= OP3_LD;
      addr_r     <= 32'h0000_0000;
    end else if (gnt_data_s) begin
      data_sel_r <= 1'b1;
      op_r       <= bus.data_op3;
      addr_r     <= bus.data_addr;
    end else if (gnt_fetch_s) begin
      data_sel_r <= 1'b0;
      op_r       <= OP3_LD;
      addr_r     <= bus.fetch_addr;
    end else begin
      data_sel_r <= data_sel_r;
      op_r       <= op_r;
      addr_r     <= addr_r;
    end
  end

  logic       mar_en_s;
  logic       mdr_en_s;
  logic       mdr_mux_s;
  logic       ram_en_s;
  logic [5:0] ram_op_s;
  logic       fetch_done_s;
  logic       data_done_s;
  logic       trap_s;

  // Decode datapath and handshake strobes from the state register.
  always_comb begin
    mar_en_s     = 1'b0;
    mdr_en_s     = 1'b0;
    mdr_mux_s    = 1'b0;
    ram_en_s     = 1'b0;
    ram_op_s     = 6'b000000;
    fetch_done_s = 1'b0;
    data_done_s  = 1'b0;
    trap_s       = 1'b0;
    case (state_r)
      ST_SETUP: begin
        mar_en_s = 1'b1;
        // stores capture register data into MDR alongside the MAR load
        mdr_en_s = op3_is_store(op_r);
      end
      ST_ACCESS: begin
        ram_en_s = 1'b1;
        ram_op_s = op_r;
      end
      ST_LATCH: begin
        mdr_en_s  = 1'b1;
        mdr_mux_s = 1'b1;
      end
      ST_DONE: begin
        fetch_done_s = ~data_sel_r;
        data_done_s  = data_sel_r;
      end
      ST_TRAP: begin
        trap_s = 1'b1;
      end
      default: begin
        mar_en_s = 1'b0;
      end
    endcase
  end

  assign bus.gnt_fetch      = gnt_fetch_s;
  assign bus.gnt_data       = gnt_data_s;
  assign bus.fetch_done     = fetch_done_s;
  assign bus.data_done      = data_done_s;
  assign bus.trap           = trap_s;
  assign bus.trap_tt        = trap_tt_r;
  assign bus.mem_addr       = addr_r;
  assign bus.MAR_Enable     = mar_en_s;
  assign bus.MDR_Enable     = mdr_en_s;
  assign bus.MDR_Mux_select = mdr_mux_s;
  assign bus.RAM_enable     = ram_en_s;
  assign bus.RAM_OpCode     = ram_op_s;
  assign bus.busy           = ~idle_s;

endmodule
